// File: rtl/multiplicador_pkg.sv
// Shared definitions for the multiplicador_if operand/result sequencer.
// Contents:
//   DEF_WIDTH, DEF_TMO_CYCLES - default operand width and per-phase wait limit
//   state_e                   - sequencer state encoding
//   cnt_width()               - bit width needed for a counter that reaches n-1
package multiplicador_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_TMO_CYCLES = 64;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StWaitDone = 3'd2,
    StRelease  = 3'd3,
    StOut      = 3'd4
  } state_e;

  // At least one bit so a limit of 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiplicador_if_if.sv
// Bundle of all handshake and data signals around multiplicador_if.
// Ports (signals):
//   in_valid/in_ready/in_a/in_b       - operand pair handshake
//   mul_start/mul_a/mul_b             - request to the shift-add multiplier
//   mul_done/mul_p                    - multiplier completion level and product
//   out_valid/out_ready/out_p         - result handshake
//   timeout                           - sticky multiplier no-response error
// Modports:
//   slave  - the sequencer side (multiplicador_if)
//   master - the environment side (operand source, multiplier, result sink)
interface multiplicador_if_if
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_p;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               timeout;

  modport slave (
    input  in_valid, in_a, in_b, mul_done, mul_p, out_ready,
    output in_ready, mul_start, mul_a, mul_b, out_valid, out_p, timeout
  );

  modport master (
    output in_valid, in_a, in_b, mul_done, mul_p, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, out_valid, out_p, timeout
  );

endinterface

// File: rtl/multiplicador_tmo.sv
// Wait-phase cycle counter for multiplicador_if.
// Ports:
//   clk     - rising-edge clock
//   rst     - synchronous active-high reset
//   clear   - force count to zero (takes priority over enable)
//   enable  - count one cycle
//   expired - count has reached TMO_CYCLES-1
module multiplicador_tmo
  import multiplicador_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = DEF_TMO_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_width(TMO_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      // Holds at the limit rather than wrapping.
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CW'(TMO_CYCLES - 1));

endmodule

// File: rtl/multiplicador_if.sv
// Sequencer that feeds operand pairs to an external shift-add multiplier using a
// level start/done protocol and returns the product through a valid/ready port.
// Zero operands short-circuit to a zero product without touching the multiplier.
// A multiplier that stalls in either wait phase raises a sticky timeout flag.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - multiplicador_if_if.slave (operand, multiplier and result signals)
module multiplicador_if
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned TMO_CYCLES = DEF_TMO_CYCLES
) (
  input logic                clk,
  input logic                rst,
  multiplicador_if_if.slave  bus
);

  state_e             state;
  logic               in_ready;
  logic               mul_start;
  logic [WIDTH-1:0]   mul_a;
  logic [WIDTH-1:0]   mul_b;
  logic               out_valid;
  logic [2*WIDTH-1:0] out_p;
  logic               timeout;
  logic               tmo_hit;  // current transaction timed out in the done phase
  logic               tmo_clear;
  logic               tmo_enable;
  logic               tmo_expired;

  // Clear on entry to either wait phase so each phase gets the full budget.
  always_comb begin
    tmo_clear  = (state == StStart) ||
                 ((state == StWaitDone) && (bus.mul_done || tmo_expired));
    tmo_enable = (state == StWaitDone) || (state == StRelease);
  end

  multiplicador_tmo #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      in_ready  <= 1'b1;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      out_valid <= 1'b0;
      out_p     <= '0;
      timeout   <= 1'b0;
      tmo_hit   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (bus.in_valid) begin
            mul_a    <= bus.in_a;
            mul_b    <= bus.in_b;
            in_ready <= 1'b0;
            tmo_hit  <= 1'b0;
            if ((bus.in_a == '0) || (bus.in_b == '0)) begin
              out_p     <= '0;
              out_valid <= 1'b1;
              state     <= StOut;
            end else begin
              mul_start <= 1'b1;
              state     <= StStart;
            end
          end
        end
        StStart: begin
          state <= StWaitDone;
        end
        StWaitDone: begin
          // done wins over a simultaneous expiry.
          if (bus.mul_done) begin
            out_p     <= bus.mul_p;
            mul_start <= 1'b0;
            state     <= StRelease;
          end else if (tmo_expired) begin
            timeout   <= 1'b1;
            tmo_hit   <= 1'b1;
            mul_start <= 1'b0;
            state     <= StRelease;
          end
        end
        StRelease: begin
          if (!bus.mul_done) begin
            if (tmo_hit) begin
              in_ready <= 1'b1;
              state    <= StIdle;
            end else begin
              out_valid <= 1'b1;
              state     <= StOut;
            end
          end else if (tmo_expired) begin
            timeout  <= 1'b1;
            in_ready <= 1'b1;
            state    <= StIdle;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mul_start = mul_start;
  assign bus.mul_a     = mul_a;
  assign bus.mul_b     = mul_b;
  assign bus.out_valid = out_valid;
  assign bus.out_p     = out_p;
  assign bus.timeout   = timeout;

endmodule
